// File: rtl/rx_ring_fifo.sv
// RX descriptor ring: byte-enabled dual-port RAM with pointer management,
// prefetching FWFT output stage, fill level and sticky error flags.
module rx_ring_fifo #(
   parameter int DATA_WIDTH   = 48,
   parameter int ADDR_WIDTH   = 5,
   parameter int BYTE_SIZE    = 8,
   parameter int OUTPUT_REG   = 0,
   parameter int AFULL_THRESH = 28,
   localparam int BE_WIDTH    = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [BE_WIDTH-1:0]   wr_byte_en,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int SKID  = (OUTPUT_REG != 0) ? 3 : 2;
   localparam int CW    = $clog2(SKID + 1);

   localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] PTR_INC = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [CW-1:0]       SKID_C  = CW'(SKID);
   localparam logic [CW-1:0]       CNT_INC = {{(CW-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   pf_ptr;

   logic [DATA_WIDTH-1:0] ram_q;
   logic                  p1v;
   logic [DATA_WIDTH-1:0] pd;
   logic                  pv;
   logic                  pv_x;

   logic [DATA_WIDTH-1:0] sk_q [SKID];
   logic [DATA_WIDTH-1:0] nq   [SKID];
   logic [CW-1:0]         sk_cnt;
   logic [CW-1:0]         n_cnt;
   logic [CW-1:0]         occ;

   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] last_q;
   logic                  push;
   logic                  pop;
   logic                  rd_en;
   logic                  ovf_q;
   logic                  udf_q;

   assign level       = wr_ptr - rd_ptr;
   assign full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign empty       = (level == '0);
   assign almost_full = (level >= AF_LVL);
   assign wr_ready    = !full;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

   assign rd_valid = (sk_cnt != '0) || pv;
   assign head     = (sk_cnt != '0) ? sk_q[0] : pd;
   assign rd_data  = rd_valid ? head : last_q;

   assign push = wr_en && wr_ready && !flush;
   assign pop  = rd_valid && rd_ready && !flush;

   // occupancy counts skid entries plus reads still travelling through the RAM
   assign occ   = sk_cnt + CW'(p1v) + CW'(pv_x);
   assign rd_en = (pf_ptr != wr_ptr) && (occ < SKID_C) && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_byte_en[b]) begin
               mem[wr_ptr[ADDR_WIDTH-1:0]][b*BYTE_SIZE +: BYTE_SIZE] <=
                  wr_data[b*BYTE_SIZE +: BYTE_SIZE];
            end
         end
      end
      if (rd_en) begin
         ram_q <= mem[pf_ptr[ADDR_WIDTH-1:0]];
      end
   end

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] pd_r;
      logic                  pv_r;

      always_ff @(posedge clk) begin
         if (p1v) begin
            pd_r <= ram_q;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pv_r <= 1'b0;
         end else if (flush) begin
            pv_r <= 1'b0;
         end else begin
            pv_r <= p1v;
         end
      end

      assign pd   = pd_r;
      assign pv   = pv_r;
      assign pv_x = pv_r;
   end else begin : g_direct
      assign pd   = ram_q;
      assign pv   = p1v;
      assign pv_x = 1'b0;
   end

   // arriving RAM data joins the skid tail unless it is popped immediately
   always_comb begin
      nq    = sk_q;
      n_cnt = sk_cnt;
      if (pop && (sk_cnt != '0)) begin
         for (int i = 0; i < SKID - 1; i++) begin
            nq[i] = sk_q[i+1];
         end
         n_cnt = sk_cnt - CNT_INC;
      end
      if (pv && !(pop && (sk_cnt == '0))) begin
         for (int i = 0; i < SKID; i++) begin
            if (CW'(i) == n_cnt) begin
               nq[i] = pd;
            end
         end
         n_cnt = n_cnt + CNT_INC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pf_ptr <= '0;
         p1v    <= 1'b0;
         sk_cnt <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
         for (int i = 0; i < SKID; i++) begin
            sk_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pf_ptr <= '0;
         p1v    <= 1'b0;
         sk_cnt <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_INC;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_INC;
         end
         if (rd_en) begin
            pf_ptr <= pf_ptr + PTR_INC;
         end
         p1v    <= rd_en;
         sk_cnt <= n_cnt;
         sk_q   <= nq;
         if (wr_en && !wr_ready) begin
            ovf_q <= 1'b1;
         end
         if (rd_ready && !rd_valid && (level != '0)) begin
            udf_q <= 1'b1;
         end
      end
   end

   // holds the last presented head so rd_data is steady while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
      end else begin
         last_q <= rd_data;
      end
   end

endmodule

// File: tb/tb_rx_ring_fifo.sv
// Bench for rx_ring_fifo: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_rx_ring_fifo;

   localparam int DW    = 48;
   localparam int AW    = 5;
   localparam int BW    = 6;
   localparam int DEPTH = 32;
   localparam int AFT   = 28;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic [BW-1:0] wr_byte_en = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic [AW:0]   level;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          overflow;
   logic          underflow;

   always #5 clk = ~clk;

   rx_ring_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .BYTE_SIZE(8),
      .OUTPUT_REG(0),
      .AFULL_THRESH(AFT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .wr_en(wr_en),
      .wr_ready(wr_ready),
      .wr_data(wr_data),
      .wr_byte_en(wr_byte_en),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready),
      .rd_data(rd_data),
      .level(level),
      .empty(empty),
      .full(full),
      .almost_full(almost_full),
      .overflow(overflow),
      .underflow(underflow)
   );

   int n_tests = 0;
   int n_fail = 0;
   int cyc_no = 0;
   int wp_m = 0;
   int dut_pops = 0;

   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] exp_q [$];
   int            pc_q [$];
   logic [DW-1:0] last_m = '0;
   logic          ovf_m = 1'b0;
   logic          udf_m = 1'b0;

   typedef struct {
      logic          wr;
      logic [DW-1:0] d;
      logic [BW-1:0] be;
      logic          rr;
      logic          fl;
      logic          rv;
      logic [DW-1:0] rd;
      logic [AW:0]   lvl;
      logic          udf;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // one clock: drive, check the model's view of this cycle, advance
   task automatic cyc(input logic wr, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input logic rr,
                      input logic fl);
      logic          rv_m;
      logic [DW-1:0] hv;
      int            lvl;
      int            a;
      wr_en = wr;
      wr_data = d;
      wr_byte_en = be;
      rd_ready = rr;
      flush = fl;
      #2;
      lvl = exp_q.size();
      rv_m = 1'b0;
      hv = last_m;
      if (lvl != 0) begin
         rv_m = (cyc_no - pc_q[0]) >= 2;
         if (rv_m) hv = exp_q[0];
      end
      chk("rd_valid", 64'(rd_valid), 64'(rv_m));
      chk("rd_data", 64'(rd_data), 64'(hv));
      chk("level", 64'(level), 64'(lvl));
      chk("empty", 64'(empty), 64'(lvl == 0));
      chk("full", 64'(full), 64'(lvl == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(lvl >= AFT));
      chk("wr_ready", 64'(wr_ready), 64'(lvl < DEPTH));
      chk("overflow", 64'(overflow), 64'(ovf_m));
      chk("underflow", 64'(underflow), 64'(udf_m));
      if (rd_valid && rr && !fl) dut_pops++;
      if (rv_m) last_m = hv;
      if (fl) begin
         exp_q.delete();
         pc_q.delete();
         wp_m = 0;
         ovf_m = 1'b0;
         udf_m = 1'b0;
      end else begin
         if (wr && lvl == DEPTH) ovf_m = 1'b1;
         if (rr && !rv_m && lvl != 0) udf_m = 1'b1;
         if (rv_m && rr) begin
            void'(exp_q.pop_front());
            void'(pc_q.pop_front());
         end
         if (wr && lvl < DEPTH) begin
            a = wp_m % DEPTH;
            for (int b = 0; b < BW; b++) begin
               if (be[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
            end
            exp_q.push_back(mem_m[a]);
            pc_q.push_back(cyc_no);
            wp_m++;
         end
      end
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   task automatic hard_reset();
      #2;
      rst_n = 1'b0;
      wr_en = 1'b0;
      rd_ready = 1'b0;
      flush = 1'b0;
      #1;
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_afull", 64'(almost_full), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_underflow", 64'(underflow), 64'd0);
      exp_q.delete();
      pc_q.delete();
      wp_m = 0;
      ovf_m = 1'b0;
      udf_m = 1'b0;
      last_m = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc_no++;
   endtask

   task automatic drain(input string nm);
      for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
         cyc(1'b0, '0, '0, 1'b1, 1'b0);
      end
      chk({nm, "_level"}, 64'(level), 64'd0);
      chk({nm, "_empty"}, 64'(empty), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            pushed;
      int            p0;
      logic          wr;
      logic          rr;
      logic [BW-1:0] be;
      logic [63:0]   r64;

      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

      tbl[0]  = '{1'b1, 48'h1, 6'h3F, 1'b0, 1'b0,
                  1'b0, 48'h0, 6'd1, 1'b0};
      tbl[1]  = '{1'b0, 48'h0, 6'h00, 1'b0, 1'b0,
                  1'b1, 48'h1, 6'd1, 1'b0};
      tbl[2]  = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0,
                  1'b0, 48'h1, 6'd0, 1'b0};
      tbl[3]  = '{1'b1, 48'hABCDEF012345, 6'h3F, 1'b1, 1'b0,
                  1'b0, 48'h1, 6'd1, 1'b0};
      tbl[4]  = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0,
                  1'b1, 48'hABCDEF012345, 6'd1, 1'b1};
      tbl[5]  = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0,
                  1'b0, 48'hABCDEF012345, 6'd0, 1'b1};
      tbl[6]  = '{1'b0, 48'h0, 6'h00, 1'b0, 1'b1,
                  1'b0, 48'hABCDEF012345, 6'd0, 1'b0};
      tbl[7]  = '{1'b1, 48'h111111111111, 6'h3F, 1'b0, 1'b0,
                  1'b0, 48'hABCDEF012345, 6'd1, 1'b0};
      tbl[8]  = '{1'b1, 48'h222222222222, 6'h03, 1'b0, 1'b0,
                  1'b1, 48'h111111111111, 6'd2, 1'b0};
      tbl[9]  = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0,
                  1'b1, 48'hABCDEF012222, 6'd1, 1'b0};
      tbl[10] = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0,
                  1'b0, 48'hABCDEF012222, 6'd0, 1'b0};

      hard_reset();

      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].wr, tbl[i].d, tbl[i].be, tbl[i].rr, tbl[i].fl);
         chk($sformatf("tbl%0d_rv", i), 64'(rd_valid), 64'(tbl[i].rv));
         chk($sformatf("tbl%0d_rd", i), 64'(rd_data), 64'(tbl[i].rd));
         chk($sformatf("tbl%0d_lvl", i), 64'(level), 64'(tbl[i].lvl));
         chk($sformatf("tbl%0d_udf", i), 64'(underflow), 64'(tbl[i].udf));
      end

      // fill to full, refuse the 33rd push
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      for (int k = 0; k < DEPTH; k++) begin
         cyc(1'b1, 48'h2000 + 48'(k), 6'h3F, 1'b0, 1'b0);
         chk($sformatf("t2_afull%0d", k), 64'(almost_full),
             64'((k + 1) >= AFT));
      end
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_wr_ready", 64'(wr_ready), 64'd0);
      chk("t2_level", 64'(level), 64'd32);
      cyc(1'b1, 48'hDEAD, 6'h3F, 1'b0, 1'b0);
      chk("t2_overflow", 64'(overflow), 64'd1);
      chk("t2_level_hold", 64'(level), 64'd32);
      drain("t2");

      // continuous streaming across pointer wraps
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      p0 = dut_pops;
      for (int k = 0; k < 100; k++) begin
         cyc(1'b1, 48'(k), 6'h3F, 1'b1, 1'b0);
      end
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t3_pops", 64'(dut_pops - p0), 64'd100);
      chk("t3_level", 64'(level), 64'd0);

      // partial-lane overwrite of a wrapped slot
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      cyc(1'b1, 48'hFFFFFFFFFFFF, 6'h3F, 1'b0, 1'b0);
      for (int k = 1; k < DEPTH; k++) begin
         cyc(1'b1, 48'h4000 + 48'(k), 6'h3F, 1'b0, 1'b0);
      end
      drain("t4");
      cyc(1'b1, 48'h123456789ABC, 6'h03, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t4_rv", 64'(rd_valid), 64'd1);
      chk("t4_data", 64'(rd_data), 64'h0000FFFFFFFF9ABC);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t4_level", 64'(level), 64'd0);

      // randomized traffic with backpressure
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      pushed = 0;
      for (int c = 0; c < 20000 && pushed < 1000; c++) begin
         wr = ($urandom_range(0, 99) < 70);
         rr = 1'($urandom_range(0, 1));
         be = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
         r64 = {$urandom(), $urandom()};
         if (wr && exp_q.size() < DEPTH) pushed++;
         cyc(wr, r64[DW-1:0], be, rr, 1'b0);
      end
      chk("t5_pushes", 64'(pushed), 64'd1000);
      drain("t5");

      // flush with data pending and rd_valid high
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, 48'h600 + 48'(k), 6'h3F, 1'b0, 1'b0);
      end
      cyc(1'b1, 48'hDEAD, 6'h3F, 1'b1, 1'b0);
      chk("t6_level10", 64'(level), 64'd10);
      chk("t6_rv_pre", 64'(rd_valid), 64'd1);
      chk("t6_udf_pre", 64'(underflow), 64'd0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      cyc(1'b1, 48'hBAD, 6'h3F, 1'b1, 1'b1);
      chk("t6_fl_level", 64'(level), 64'd0);
      chk("t6_fl_rv", 64'(rd_valid), 64'd0);
      chk("t6_fl_ovf", 64'(overflow), 64'd0);
      cyc(1'b1, 48'h777777777777, 6'h3F, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t6_post_rv", 64'(rd_valid), 64'd1);
      chk("t6_post_data", 64'(rd_data), 64'h0000777777777777);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t6_post_level", 64'(level), 64'd0);

      // asynchronous reset in the middle of a stream
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 48'h900 + 48'(k), 6'h3F, 1'b1, 1'b0);
      end
      hard_reset();
      cyc(1'b1, 48'h5A5A5A5A5A5A, 6'h3F, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t6_rst_rv", 64'(rd_valid), 64'd1);
      chk("t6_rst_data", 64'(rd_data), 64'h00005A5A5A5A5A5A);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t6_rst_level", 64'(level), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
